// File: rtl/pattern_timer_fsm.sv
// Serial command timer: finds PATTERN on x, shifts in a DLY_W-bit delay, times (delay+1)*CNT_UNIT cycles,
// then holds done until ack (or an optional ACK_TO timeout). All outputs are registered or decoded from state.
module pattern_timer_fsm #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1101,
  parameter int               DLY_W    = 4,
  parameter int               CNT_UNIT = 1000,
  parameter int               ACK_TO   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             ack,
  output logic             shift_ena,
  output logic             counting,
  output logic [DLY_W-1:0] count,
  output logic             done,
  output logic             timeout
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = $clog2(DLY_W + 1);
  localparam int UNIT_W = $clog2(CNT_UNIT + 1);
  localparam int WAIT_W = (ACK_TO > 0) ? $clog2(ACK_TO + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COUNT, WAIT} state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   hist;
  logic [FILL_W-1:0]  fill;
  logic [DLY_W-1:0]   dly;
  logic [BIT_W-1:0]   bit_cnt;
  logic [UNIT_W-1:0]  unit_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  logic [PAT_W-1:0]   window;
  logic [DLY_W-1:0]   dly_shift;
  logic               match;
  logic               last_bit;
  logic               unit_wrap;
  logic               ack_expire;

  assign window    = PAT_W'({hist, x});
  assign dly_shift = DLY_W'({dly, x});
  // fill counts bits already held; the incoming bit completes the window
  assign match      = (fill >= FILL_W'(PAT_W - 1)) && (window == PATTERN);
  assign last_bit   = (bit_cnt == BIT_W'(DLY_W - 1));
  assign unit_wrap  = (unit_cnt == UNIT_W'(CNT_UNIT - 1));
  assign ack_expire = (ACK_TO > 0) && (wait_cnt == WAIT_W'(ACK_TO - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (match)                    state_nxt = SHIFT;
      SHIFT:   if (last_bit)                 state_nxt = COUNT;
      COUNT:   if (unit_wrap && count == '0) state_nxt = WAIT;
      WAIT:    if (ack || ack_expire)        state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_ena = (state == SHIFT);
    counting  = (state == COUNT);
    done      = (state == WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist     <= '0;
      fill     <= '0;
      dly      <= '0;
      bit_cnt  <= '0;
      unit_cnt <= '0;
      wait_cnt <= '0;
      count    <= '0;
      timeout  <= 1'b0;
    end else begin
      // ack on the expiry cycle suppresses the pulse
      timeout <= (state == WAIT) && !ack && ack_expire;

      if (state == IDLE) begin
        hist <= window;
        if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
      end else begin
        hist <= '0;
        fill <= '0;
      end

      if (state == SHIFT) begin
        dly     <= dly_shift;
        bit_cnt <= bit_cnt + 1'b1;
        if (last_bit) begin
          count    <= dly_shift;
          unit_cnt <= '0;
          bit_cnt  <= '0;
        end
      end else begin
        bit_cnt <= '0;
      end

      if (state == COUNT) begin
        if (unit_wrap) begin
          unit_cnt <= '0;
          if (count != '0) count <= count - 1'b1;
        end else begin
          unit_cnt <= unit_cnt + 1'b1;
        end
      end

      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pattern_timer_fsm.sv
// Two instances (1101/unit 4/no ack timeout and 0110/unit 3/ACK_TO 5) share x, ack and reset_n;
// a timeline model (phase + elapsed cycles) predicts every output each cycle.
module tb_pattern_timer_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       x;
  logic       ack;
  logic [1:0] se, cn, dn, tmo;
  logic [3:0] ct0, ct1;

  int checks = 0;
  int errors = 0;

  localparam int P_PW [2] = '{4, 4};
  localparam int P_PAT[2] = '{13, 6};
  localparam int P_DW [2] = '{4, 4};
  localparam int P_U  [2] = '{4, 3};
  localparam int P_TO [2] = '{0, 5};

  // model: phase 0 search, 1 capture, 2 timing, 3 awaiting ack
  int m_phase[2], m_t[2], m_d[2], m_hist[2], m_fill[2];
  bit m_to[2];
  int se_n[2], cn_n[2], dn_n[2], to_n[2];

  always #5 clk = ~clk;

  pattern_timer_fsm #(.PAT_W(4), .PATTERN(4'b1101), .DLY_W(4), .CNT_UNIT(4), .ACK_TO(0)) u0 (
    .clk(clk), .reset_n(reset_n), .x(x), .ack(ack),
    .shift_ena(se[0]), .counting(cn[0]), .count(ct0), .done(dn[0]), .timeout(tmo[0]));

  pattern_timer_fsm #(.PAT_W(4), .PATTERN(4'b0110), .DLY_W(4), .CNT_UNIT(3), .ACK_TO(5)) u1 (
    .clk(clk), .reset_n(reset_n), .x(x), .ack(ack),
    .shift_ena(se[1]), .counting(cn[1]), .count(ct1), .done(dn[1]), .timeout(tmo[1]));

  task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_t[i] = 0; m_d[i] = 0; m_hist[i] = 0; m_fill[i] = 0; m_to[i] = 0;
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < 2; i++) begin
      se_n[i] = 0; cn_n[i] = 0; dn_n[i] = 0; to_n[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input bit xv, input bit av);
    int w;
    m_to[i] = 0;
    case (m_phase[i])
      0: begin
        w = ((m_hist[i] << 1) | int'(xv)) & ((1 << P_PW[i]) - 1);
        if (m_fill[i] < P_PW[i]) m_fill[i]++;
        if (m_fill[i] == P_PW[i] && w == P_PAT[i]) begin
          m_phase[i] = 1; m_t[i] = 0; m_d[i] = 0;
        end else m_hist[i] = w;
      end
      1: begin
        m_d[i] = m_d[i] * 2 + int'(xv);
        m_t[i]++;
        if (m_t[i] == P_DW[i]) begin m_phase[i] = 2; m_t[i] = 0; end
      end
      2: begin
        m_t[i]++;
        if (m_t[i] == (m_d[i] + 1) * P_U[i]) begin m_phase[i] = 3; m_t[i] = 0; end
      end
      default: begin
        m_t[i]++;
        if (av || (P_TO[i] > 0 && m_t[i] == P_TO[i])) begin
          m_to[i] = !av;
          m_phase[i] = 0; m_t[i] = 0; m_hist[i] = 0; m_fill[i] = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    logic [3:0] c;
    for (int i = 0; i < 2; i++) begin
      c = (i == 0) ? ct0 : ct1;
      chk("shift_ena", i, 16'(se[i]),  16'(m_phase[i] == 1));
      chk("counting",  i, 16'(cn[i]),  16'(m_phase[i] == 2));
      chk("done",      i, 16'(dn[i]),  16'(m_phase[i] == 3));
      chk("timeout",   i, 16'(tmo[i]), 16'(m_to[i]));
      if (m_phase[i] == 2) chk("count", i, 16'(c), 16'(m_d[i] - m_t[i] / P_U[i]));
      se_n[i] += int'(se[i]); cn_n[i] += int'(cn[i]);
      dn_n[i] += int'(dn[i]); to_n[i] += int'(tmo[i]);
    end
  endtask

  task automatic step(input bit xv, input bit av);
    x = xv; ack = av;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, xv, av);
    #1;
    check_all();
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(bits[k], 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_se"}, 0, 16'(se), 16'd0);
    chk({tag, "_cn"}, 0, 16'(cn), 16'd0);
    chk({tag, "_dn"}, 0, 16'(dn), 16'd0);
    chk({tag, "_to"}, 0, 16'(tmo), 16'd0);
    chk({tag, "_ct"}, 0, 16'({ct1, ct0}), 16'd0);
  endtask

  initial begin
    int k;
    reset_n = 1'b0; x = 1'b0; ack = 1'b0;
    model_reset(); clear_tally();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // 1101 then delay 2 on u0: 4 shift cycles, 12 counting cycles, then done until ack
    feed(16'b1101_0010, 8);
    for (int n = 0; n < 14; n++) step(1'b0, 1'b0);
    chk("A_shift_cycles", 0, 16'(se_n[0]), 16'd4);
    chk("A_count_cycles", 0, 16'(cn_n[0]), 16'd12);
    chk("A_done_held", 0, 16'(dn[0]), 16'd1);
    step(1'b0, 1'b1);
    chk("A_done_after_ack", 0, 16'(dn[0]), 16'd0);

    // 0110 with delay 0 on u1: 3 counting cycles, done 5 cycles, one timeout pulse
    clear_tally();
    feed(16'b0110_0000, 8);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b0);
    chk("B_shift_cycles", 1, 16'(se_n[1]), 16'd4);
    chk("B_count_cycles", 1, 16'(cn_n[1]), 16'd3);
    chk("B_done_cycles", 1, 16'(dn_n[1]), 16'd5);
    chk("B_timeout_pulses", 1, 16'(to_n[1]), 16'd1);

    // 0110 with delay 15 on u1: 48 counting cycles, ack on 5th done cycle beats the timeout
    clear_tally();
    feed(16'b0110_1111, 8);
    k = 0;
    while (dn[1] !== 1'b1 && k < 200) begin step(1'b0, 1'b0); k++; end
    chk("C_reach_done", 1, 16'(dn[1]), 16'd1);
    chk("C_count_cycles", 1, 16'(cn_n[1]), 16'd48);
    clear_tally();
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    chk("C_done_cycles", 1, 16'(dn_n[1]), 16'd4);
    chk("C_no_timeout", 1, 16'(to_n[1]), 16'd0);
    k = 0;
    while (!(m_phase[0] == 0 && m_phase[1] == 0) && k < 300) begin step(1'b0, m_phase[0] == 3); k++; end
    chk("C_drain", 0, 16'(se | cn | dn), 16'd0);

    // overlapping prefix: 1110 gives nothing, the following 1 matches
    feed(16'b1110, 4);
    chk("D_no_early_match", 0, 16'(se[0]), 16'd0);
    step(1'b1, 1'b0);
    chk("D_overlap_match", 0, 16'(se[0]), 16'd1);
    feed(16'b1111, 4);
    repeat (10) step(1'b0, 1'b0);
    chk("D_mid_count", 0, 16'(cn[0]), 16'd1);

    // asynchronous reset between edges clears outputs at once
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    feed(16'b101, 3);
    chk("E_partial_no_match", 0, 16'(se[0]), 16'd0);
    feed(16'b1101, 4);
    chk("E_full_match", 0, 16'(se[0]), 16'd1);

    for (int n = 0; n < 4000; n++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
